operand_loader: RTL
===================

Name: operand_loader

Overview:
- Upstream operand-capture stage for the 4-bit add/subtract datapath.
- Debounces two push-buttons (enter, clear) and captures operand A, then operand B, from 4 slide switches.
- Holds both operands stable on A/B for the arithmetic block and flags when a complete pair is loaded.
- All state is synchronous to one clock; buttons and switches are asynchronous board inputs.

Parameters:
- DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal range >= 2.
- CNT_W, default 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  4  operand switches, asynchronous, sampled through a 2-flop synchronizer.
- btn_enter  input  1  raw enter button, active-high, asynchronous.
- btn_clear  input  1  raw clear button, active-high, asynchronous.
- A  output  4  captured operand A, registered.
- B  output  4  captured operand B, registered.
- operands_valid  output  1  high while both A and B hold a completed entry.
- state  output  2  FSM state for LEDs: 00 WAIT_A, 01 WAIT_B, 10 READY.

Behaviour:
- Reset (rst_n low, asynchronous): A=0, B=0, operands_valid=0, state=WAIT_A, synchronizers=0, debounced levels=0, counters=0, press pulses=0.
- Synchronizers: sw, btn_enter and btn_clear each pass through 2 flops before any use.
- Debounce (independent per button):
  - The counter increments each cycle that the synced level differs from the debounced level.
  - The counter resets to 0 on any cycle where the two levels are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced value and the counter resets.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press pulse:
  - A registered, one-cycle pulse on each 0->1 transition of the debounced level.
  - Holding a button yields exactly one pulse.
  - A new pulse requires a debounced release first.
- Latency: a clean press reaches its pulse DEBOUNCE_CYCLES+3 cycles after the raw edge. The FSM and outputs update on the clock edge that samples the pulse, so they are visible 1 cycle after the pulse.
- FSM on enter pulse:
  - WAIT_A: A <= synced sw; go to WAIT_B.
  - WAIT_B: B <= synced sw; operands_valid <= 1; go to READY.
  - READY: A <= synced sw; B is held; operands_valid <= 0; go to WAIT_B (starts a new pair).
- Clear pulse in any state: A <= 0, B <= 0, operands_valid <= 0, state <= WAIT_A.
- Simultaneous clear and enter pulses: clear wins; enter is discarded.
- No pulse: all outputs hold their values.
- operands_valid is 1 only in READY.
- Switch changes never affect A/B except at an accepted enter pulse.
- Reset asserted mid-debounce or mid-entry returns immediately to reset values. No pulse may be generated by reset deassertion, even if a button is held; a held button produces one pulse after a full debounce period.
- A and B are raw 4-bit values with no sign interpretation; the downstream block treats them as two's-complement or unsigned.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset, then sw=4'h5, clean enter press; sw=4'h3, second press -> after the first pulse A=5, state=01. After the second pulse B=3, operands_valid=1, state=10.
- Enter bouncing 1,0,1,0 on single cycles, then low -> no pulse; A, B and state unchanged. Hold high for 20 cycles -> exactly one pulse, 7 cycles after the stable edge.
- From READY (A=5, B=3), sw=4'hC, enter press -> A=C, B=3, operands_valid=0, state=01.
- In WAIT_B with A=9, drive clear and enter so both pulses land in the same cycle -> A=0, B=0, operands_valid=0, state=00.
- Assert rst_n low for 1 cycle mid-debounce with enter held -> outputs 0 immediately. After release, one pulse only after a full debounce period, then A=sw.
- Toggle sw for 50 cycles in READY with no presses -> A, B and operands_valid remain constant.

Source files
------------

// File: rtl/operand_loader.sv
`default_nettype none
//============================================================================
// Module   : operand_loader
// Purpose  : Debounces the enter/clear push-buttons and captures operand A,
//            then operand B, from four slide switches. Both operands are held
//            stable for the downstream add/subtract block, and a flag marks
//            when a complete pair has been loaded.
// Revision : 1.0  initial release
//============================================================================
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       operands_valid,
    output logic [1:0] state
);

    // Terminal debounce count: a level change is accepted on the cycle that
    // finds the counter at this value with the levels still disagreeing.
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is enter, index 1 is clear.
    localparam int C_NUM_BTN = 2;
    localparam int C_ENTER   = 0;
    localparam int C_CLEAR   = 1;

    typedef enum logic [1:0] {
        S_WAIT_A = 2'b00,
        S_WAIT_B = 2'b01,
        S_READY  = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [3:0]           r_sw_meta;
    logic [3:0]           r_sw_sync;
    logic [C_NUM_BTN-1:0] r_btn_meta;
    logic [C_NUM_BTN-1:0] r_btn_sync;
    logic [C_NUM_BTN-1:0] w_press;

    // Two-flop synchronizers for the switches and both raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= {btn_clear, btn_enter};
            r_btn_sync <= r_btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce and rising-edge press pulse
    // ------------------------------------------------------------------
    for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_debounce
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_level_d;
        logic             r_pulse;

        // Count cycles of disagreement between the synced and debounced
        // levels; any agreeing cycle restarts the count, so short glitches
        // never reach the terminal value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_btn_sync[i] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_cnt   <= '0;
                r_level <= r_btn_sync[i];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        // One-cycle registered pulse on each 0->1 of the debounced level;
        // both flops reset low so reset release can never fake an edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_level_d <= 1'b0;
                r_pulse   <= 1'b0;
            end else begin
                r_level_d <= r_level;
                r_pulse   <= r_level & ~r_level_d;
            end
        end

        assign w_press[i] = r_pulse;
    end

    // ------------------------------------------------------------------
    // Operand capture FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_valid;
    logic [3:0] w_a_nxt;
    logic [3:0] w_b_nxt;
    logic       w_valid_nxt;

    // State and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state/operand logic: clear has priority over enter; without a
    // pulse everything holds, so switch motion never reaches A/B.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_valid_nxt = r_valid;

        if (w_press[C_CLEAR]) begin
            w_state_nxt = S_WAIT_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_valid_nxt = 1'b0;
        end else if (w_press[C_ENTER]) begin
            case (r_state)
                S_WAIT_A: begin
                    w_a_nxt     = r_sw_sync;
                    w_state_nxt = S_WAIT_B;
                end
                S_WAIT_B: begin
                    w_b_nxt     = r_sw_sync;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_READY;
                end
                S_READY: begin
                    // Start a new pair; B keeps its old value until replaced.
                    w_a_nxt     = r_sw_sync;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_WAIT_B;
                end
                default: begin
                    w_state_nxt = S_WAIT_A;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign A              = r_a;
    assign B              = r_b;
    assign operands_valid = r_valid;
    assign state          = r_state;

endmodule
`default_nettype wire
